// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
// Shared definitions for the uart_tx round-robin scheduler:
//   - state encoding of the scheduler FSM
//   - frame-format limits and oversampling ratio
//   - clamp_bitnum() : forces the data-bit count into 5..8
//   - frame_len()    : frame length in clkx16 cycles, 16*(1 + B + P + S)
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam int BITNUM_MIN      = 5;
  localparam int BITNUM_MAX      = 8;
  localparam int SAMPLES_PER_BIT = 16;

  function automatic logic [3:0] clamp_bitnum(input logic [3:0] bitnum);
    if (bitnum < 4'(BITNUM_MIN)) return 4'(BITNUM_MIN);
    if (bitnum > 4'(BITNUM_MAX)) return 4'(BITNUM_MAX);
    return bitnum;
  endfunction

  // Start bit + data bits + optional check bit + optional stop bit.
  // Largest case is 16*11 = 176, which fits the 8-bit frame counter.
  function automatic logic [7:0] frame_len(input logic [3:0] bitnum,
                                           input logic       parity,
                                           input logic       stop);
    return 8'(SAMPLES_PER_BIT * (1 + int'(bitnum) + int'(parity) + int'(stop)));
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter
// Combinational requester selection.
//   i_req   : request vector
//   i_ptr   : index that has highest priority this round
//   o_grant : one-hot winner (all zero when nothing requests)
//   o_idx   : index of the winner
//   o_valid : at least one request present
// Build option UART_TX_ARB_PRIO_EN: fixed priority, lowest index wins,
// i_ptr is ignored.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef UART_TX_ARB_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) o_idx = IDX_W'(k);
    end
  end
`else
  // Scan from the farthest position back toward i_ptr so the last hit,
  // i.e. the one closest to i_ptr going upward with wrap, wins.
  always_comb begin
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) o_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
    end
  end
`endif

  always_comb begin
    o_valid = |i_req;
    o_grant = '0;
    if (o_valid) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares one uart_tx between NUM_REQ byte requesters. A winner is chosen
// in IDLE, its byte and the frame config are registered, and a single
// cycle o_data_valid pulse (with the matching o_ack bit) launches the
// frame. The frame is timed locally from the config because uart_tx
// reports no completion, then GAP_CYC idle cycles are inserted.
// Ports:
//   i_clkx16, i_rst_n (sync, active low)
//   i_req / o_ack           : per-requester handshake
//   i_data                  : NUM_REQ packed bytes
//   i_cfg_*                 : frame config, sampled at grant
//   o_data, o_data_valid    : to uart_tx
//   o_exist_*, o_bitnum     : frame config to uart_tx (bitnum clamped)
//   o_busy, o_grant_id      : status
// Build option UART_TX_ARB_PRIO_EN: fixed priority instead of round robin.
//
// state  | meaning
// IDLE   | waiting for any request; grant taken on the sampling edge
// LAUNCH | one cycle: data_valid + ack, frame counter loaded with F-1
// BUSY   | frame on the line, counts down F cycles
// GAP    | inter-frame idle, counts down GAP_CYC cycles
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYC = 16
) (
  input  logic                       i_clkx16,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*8-1:0]       i_data,
  output logic [NUM_REQ-1:0]         o_ack,
  input  logic                       i_cfg_oddcheck,
  input  logic                       i_cfg_evencheck,
  input  logic                       i_cfg_stop,
  input  logic [3:0]                 i_cfg_bitnum,
  output logic [7:0]                 o_data,
  output logic                       o_data_valid,
  output logic                       o_exist_oddcheck,
  output logic                       o_exist_evencheck,
  output logic                       o_exist_stop,
  output logic [3:0]                 o_bitnum,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int         IDX_W    = $clog2(NUM_REQ);
  localparam logic [7:0] GAP_LOAD = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic               w_grant_take;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic [NUM_REQ-1:0] w_arb_grant;
  logic               w_arb_valid;
  logic [NUM_REQ-1:0] r_grant_oh;
  logic [7:0]         r_data;
  logic               r_odd, r_even, r_stop;
  logic [3:0]         r_bitnum;
  logic [IDX_W-1:0]   r_grant_id;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_grant(w_arb_grant),
    .o_idx  (w_arb_idx),
    .o_valid(w_arb_valid)
  );

`ifdef UART_TX_ARB_PRIO_EN
  assign w_ptr_nxt = '0;
`else
  assign w_ptr_nxt = IDX_W'((int'(w_arb_idx) + 1) % NUM_REQ);
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_grant_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_grant_take = 1'b1;
          w_state_nxt  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // Config registers already hold the clamped, granted values.
        w_cnt_nxt   = frame_len(r_bitnum, r_odd | r_even, r_stop) - 8'd1;
        w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (r_cnt == 8'd0) begin
          if (GAP_CYC == 0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = GAP_LOAD;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == 8'd0) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clkx16) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_grant_oh <= '0;
      r_data     <= '0;
      r_odd      <= 1'b0;
      r_even     <= 1'b0;
      r_stop     <= 1'b0;
      r_bitnum   <= '0;
      r_grant_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant_take) begin
        r_ptr      <= w_ptr_nxt;
        r_grant_oh <= w_arb_grant;
        r_data     <= i_data[8*int'(w_arb_idx) +: 8];
        r_odd      <= i_cfg_oddcheck;
        r_even     <= i_cfg_evencheck;
        r_stop     <= i_cfg_stop;
        r_bitnum   <= clamp_bitnum(i_cfg_bitnum);
        r_grant_id <= w_arb_idx;
      end
    end
  end

  assign o_ack             = (r_state == ST_LAUNCH) ? r_grant_oh : '0;
  assign o_data_valid      = (r_state == ST_LAUNCH);
  assign o_busy            = (r_state != ST_IDLE);
  assign o_data            = r_data;
  assign o_exist_oddcheck  = r_odd;
  assign o_exist_evencheck = r_even;
  assign o_exist_stop      = r_stop;
  assign o_bitnum          = r_bitnum;
  assign o_grant_id        = r_grant_id;

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin scheduler that shares one uart_tx instance between NUM_REQ byte requesters.
- Grants one requester at a time and launches the frame with a single-cycle o_data_valid pulse, because uart_tx starts on a rising edge of data_valid.
- Drives the frame config (parity, stop, bitnum) alongside the data.
- uart_tx has no done/busy output, so this block times the whole frame itself from the config, then inserts an inter-frame idle gap.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYC, 16, idle i_clkx16 cycles after each frame (0..255); 16 gives one idle bit time.

Ports:
- i_clkx16  in  1  16x baud clock; the only clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req  in  NUM_REQ  per-requester request; held until matching o_ack.
- i_data  in  NUM_REQ*8  byte of requester k on bits [8k+7:8k].
- o_ack  out  NUM_REQ  one-cycle grant/accept pulse, one-hot.
- i_cfg_oddcheck  in  1  odd parity enable, sampled at grant.
- i_cfg_evencheck  in  1  even parity enable, sampled at grant.
- i_cfg_stop  in  1  stop bit enable, sampled at grant.
- i_cfg_bitnum  in  4  data bits (5..8), sampled at grant.
- o_data  out  8  byte to uart_tx i_data.
- o_data_valid  out  1  launch pulse to uart_tx i_data_valid.
- o_exist_oddcheck  out  1  to uart_tx.
- o_exist_evencheck  out  1  to uart_tx.
- o_exist_stop  out  1  to uart_tx.
- o_bitnum  out  4  clamped bitnum to uart_tx.
- o_busy  out  1  high in every state except IDLE.
- o_grant_id  out  clog2(NUM_REQ)  index of the last granted requester.

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - state=IDLE; all outputs 0; RR pointer=0, so requester 0 has highest priority first.
  - Reset mid-frame aborts timing immediately. The partial uart_tx frame is not the arbiter's concern; uart_tx is reset by the same system reset.
- States: IDLE, LAUNCH, BUSY, GAP.
- IDLE:
  - If any i_req bit is set, select winner g by round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - At the same edge: register o_data=i_data[g], the config, o_grant_id=g; update the pointer; move to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - o_data_valid=1 and o_ack[g]=1.
  - Load the frame counter with F-1, where F = 16*(1 + B + P + S).
  - B = clamped bitnum: values <5 become 5, >8 become 8; o_bitnum carries the clamped value.
  - P = oddcheck | evencheck (both set counts as one check bit; both forwarded unchanged).
  - S = stop.
  - Counter is 8 bits wide; maximum F = 176.
  - Go to BUSY.
- BUSY: decrement each cycle. At 0, go to GAP with the counter loaded to GAP_CYC-1; if GAP_CYC==0, go directly to IDLE.
- GAP: decrement; at 0, go to IDLE.
- Latency:
  - o_data_valid asserts 1 cycle after IDLE samples i_req.
  - Minimum spacing between launch pulses = F + GAP_CYC + 2 cycles.
- o_data and the config outputs stay stable from LAUNCH until the next grant.
- o_data_valid is 0 in all states other than LAUNCH, which guarantees a fresh rising edge for the next frame.
- Requests are sampled only in IDLE. Changes to i_req or i_data during LAUNCH/BUSY/GAP are ignored.
- A request dropped before ack is simply not served. Once the grant edge has passed, the frame completes regardless.
- Simultaneous requests: exactly one ack per frame. Every continuously-requesting requester is served within NUM_REQ frames.
- Config changes mid-frame do not affect the frame in progress.

Optional Feature:
- Macro: UART_TX_ARB_PRIO_EN.
- Defined: fixed priority; the lowest index wins and the RR pointer is unused (tied to 0).
- Undefined: round-robin as described above.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state encoding (IDLE/LAUNCH/BUSY/GAP);
  - BITNUM_MIN=5, BITNUM_MAX=8;
  - SAMPLES_PER_BIT=16;
  - the frame-length function F(B,P,S).
- One sub-module, uart_rr_arbiter: combinational request vector plus pointer in, one-hot grant and index out; the pointer register stays in the parent. The fixed-priority mode is selected inside it.

Test Plan:
- Single request: NUM_REQ=4, GAP_CYC=16, req[2]=1, data=8'hA5, bitnum=8, no parity, stop=1 -> one o_data_valid pulse with o_data=A5, o_ack=4'b0100 in the same cycle, o_busy high for 1+160+16 cycles.
- All four requesting continuously -> acks in order 0,1,2,3,0; launch pulses spaced exactly 178 cycles apart.
- Frame-length corners:
  - bitnum=5, no parity, no stop -> BUSY lasts 96 cycles.
  - bitnum=8, odd+even, stop -> 176 cycles.
  - bitnum=4'hF -> o_bitnum=8, 160 cycles with stop.
- GAP_CYC=0 and back-to-back requests -> o_data_valid low for exactly F+1 cycles between pulses (rising edge preserved).
- Reset: assert i_rst_n=0 for one edge mid-BUSY -> next cycle all outputs 0, IDLE; a subsequent req[3] with req[0] also set grants 0 first (pointer reset).
- UART_TX_ARB_PRIO_EN defined with req=4'b1010 held -> requester 1 is granted every frame and requester 3 never.
